// File: rtl/byte_queue_pkg.sv
// Shared types and default sizing for the byte_queue block.
package byte_queue_pkg;

  localparam int QUEUE_WIDTH = 8;
  localparam int QUEUE_DEPTH = 8;

  // Enqueue handshake states towards the deserializer.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } enq_state_e;

endpackage

// File: rtl/byte_queue_storage.sv
// queue_storage: register-array FIFO core with write/read pointers and an
// explicit occupancy count. The caller guarantees wr_en_i is only asserted
// when not full and rd_en_i only when not empty.
module queue_storage
  import byte_queue_pkg::*;
#(
  parameter int WIDTH = QUEUE_WIDTH,
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;

  // Next-state for pointers (wrap naturally modulo DEPTH) and the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards all stored contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data array; entries beyond the count are meaningless, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/byte_queue.sv
// byte_queue: accepts bytes from the deserializer with a one-cycle ack
// handshake, buffers them in queue_storage and pops them on request.
// Optional build macro: BYTE_QUEUE_ERR_EN adds a sticky err_out flag for
// pops on empty and enqueue attempts while full.
module byte_queue
  import byte_queue_pkg::*;
#(
  parameter int WIDTH = QUEUE_WIDTH,
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic                   clk_100khz,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   enqueue_in,
  output logic                   ack_out,
  input  logic                   dequeue_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [$clog2(DEPTH):0] len_out,
  output logic                   empty_out,
  output logic                   full_out
`ifdef BYTE_QUEUE_ERR_EN
  ,
  output logic                   err_out
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;

  enq_state_e       state_q, state_d;
  logic             ack_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [WIDTH-1:0] rd_data_s;
  logic [LW-1:0]    count_s;
  logic             full_s;
  logic             empty_s;

  assign full_s  = (count_s == LW'(DEPTH));
  assign empty_s = (count_s == LW'(0));
  assign rd_en_s = dequeue_in & ~empty_s;

  queue_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk_i     (clk_100khz),
    .rst_i     (reset),
    .wr_en_i   (wr_en_s),
    .wr_data_i (data_in),
    .rd_en_i   (rd_en_s),
    .rd_data_o (rd_data_s),
    .count_o   (count_s)
  );

  // Enqueue FSM: accept on the pre-edge count, pulse ack, then wait for
  // data_ready to drop so one byte is never stored twice.
  always_comb begin
    state_d = state_q;
    wr_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (enqueue_in && !full_s) begin
          wr_en_s = 1'b1;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!enqueue_in) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registered ack and registered pop outputs.
  always_ff @(posedge clk_100khz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK);
      valid_q <= rd_en_s;
      if (rd_en_s) begin
        data_q <= rd_data_s;
      end
    end
  end

`ifdef BYTE_QUEUE_ERR_EN
  logic err_q;

  // Sticky error: pop on empty or enqueue attempt while full in IDLE.
  always_ff @(posedge clk_100khz or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (dequeue_in & empty_s)
                     | ((state_q == IDLE) & enqueue_in & full_s);
    end
  end

  assign err_out = err_q;
`endif

  assign ack_out   = ack_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign len_out   = count_s;
  assign empty_out = empty_s;
  assign full_out  = full_s;

endmodule

// File: tb/tb_byte_queue.sv
// Scoreboard bench for byte_queue: stimulus pushes expected popped bytes,
// a negedge monitor pops and compares whenever valid_out is high.
module tb_byte_queue;

  logic       clk_100khz = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] data_in    = 8'h00;
  logic       enqueue_in = 1'b0;
  logic       dequeue_in = 1'b0;
  logic       ack_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic [3:0] len_out;
  logic       empty_out;
  logic       full_out;
`ifdef BYTE_QUEUE_ERR_EN
  logic       err_out;
`endif

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  byte_queue #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_100khz (clk_100khz),
    .reset      (reset),
    .data_in    (data_in),
    .enqueue_in (enqueue_in),
    .ack_out    (ack_out),
    .dequeue_in (dequeue_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .len_out    (len_out),
    .empty_out  (empty_out),
    .full_out   (full_out)
`ifdef BYTE_QUEUE_ERR_EN
    ,
    .err_out    (err_out)
`endif
  );

  always #5 clk_100khz = ~clk_100khz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_100khz);
    #1;
  endtask

  // Deserializer-style enqueue: hold data_ready until the cycle after ack.
  task automatic enq(input logic [7:0] b, input string name);
    int lat;
    lat = 0;
    data_in    = b;
    enqueue_in = 1'b1;
    do begin
      tick();
      lat++;
    end while (!ack_out && lat < 20);
    chk({name, "_ack_latency"}, lat, 1);
    tick();
    chk({name, "_ack_width"}, {31'd0, ack_out}, 32'd0);
    enqueue_in = 1'b0;
    tick();
  endtask

  task automatic pop_one(input logic [7:0] exp);
    exp_q.push_back(exp);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
  endtask

  // Monitor: every valid_out beat must match the oldest expected byte.
  always @(negedge clk_100khz) begin
    if (!reset && valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got data 0x%0h with no pop expected", data_out);
      end else begin
        chk("pop_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk_100khz);
    #1;
    chk("rst_ack",   {31'd0, ack_out},   32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_len",   {28'd0, len_out},   32'd0);
    chk("rst_empty", {31'd0, empty_out}, 32'd1);
    chk("rst_full",  {31'd0, full_out},  32'd0);
    chk("rst_data",  {24'd0, data_out},  32'd0);
`ifdef BYTE_QUEUE_ERR_EN
    chk("rst_err",   {31'd0, err_out},   32'd0);
`endif
    reset = 1'b0;
    tick();

    // Pop on empty is ignored.
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("empty_pop_valid", {31'd0, valid_out}, 32'd0);
    chk("empty_pop_len",   {28'd0, len_out},   32'd0);
`ifdef BYTE_QUEUE_ERR_EN
    chk("err_set_empty_pop", {31'd0, err_out}, 32'd1);
`endif

    // Single handshake.
    enq(8'h55, "enq55");
    chk("len_after_55",   {28'd0, len_out},   32'd1);
    chk("empty_after_55", {31'd0, empty_out}, 32'd0);
    tick();
    tick();
    chk("len_single_write", {28'd0, len_out}, 32'd1);
    pop_one(8'h55);
    chk("len_after_pop55", {28'd0, len_out}, 32'd0);

    // Fill to full.
    for (int i = 1; i <= 8; i++) enq(8'(i), "fill");
    chk("full_flag", {31'd0, full_out}, 32'd1);
    chk("full_len",  {28'd0, len_out},  32'd8);

    // Ninth byte is held off while full.
    data_in    = 8'h09;
    enqueue_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_ack_when_full", {31'd0, ack_out}, 32'd0);
    end
    exp_q.push_back(8'h01);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("no_ack_on_pop_edge", {31'd0, ack_out}, 32'd0);
    chk("len_after_full_pop", {28'd0, len_out}, 32'd7);
    tick();
    chk("ack_after_pop", {31'd0, ack_out}, 32'd1);
    chk("len_refilled",  {28'd0, len_out}, 32'd8);
    tick();
    enqueue_in = 1'b0;
    tick();

    // Drain all with dequeue held high; pointers wrap.
    for (int i = 2; i <= 9; i++) exp_q.push_back(8'(i));
    dequeue_in = 1'b1;
    repeat (8) tick();
    dequeue_in = 1'b0;
    chk("drain_empty", {31'd0, empty_out}, 32'd1);
    chk("drain_len",   {28'd0, len_out},   32'd0);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("extra_pop_valid", {31'd0, valid_out}, 32'd0);
    chk("extra_pop_data",  {24'd0, data_out},  32'h09);

    // Simultaneous write and pop at len 3.
    enq(8'h10, "e10");
    enq(8'h11, "e11");
    enq(8'h12, "e12");
    chk("len3", {28'd0, len_out}, 32'd3);
    exp_q.push_back(8'h10);
    data_in    = 8'h13;
    enqueue_in = 1'b1;
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("simul_ack", {31'd0, ack_out}, 32'd1);
    chk("simul_len", {28'd0, len_out}, 32'd3);
    tick();
    enqueue_in = 1'b0;
    tick();
    for (int i = 8'h11; i <= 8'h13; i++) exp_q.push_back(8'(i));
    dequeue_in = 1'b1;
    repeat (3) tick();
    dequeue_in = 1'b0;
    chk("simul_drain_len", {28'd0, len_out}, 32'd0);

    // Reset during ACK with four entries.
    enq(8'h20, "e20");
    enq(8'h21, "e21");
    enq(8'h22, "e22");
    data_in    = 8'h23;
    enqueue_in = 1'b1;
    tick();
    chk("pre_rst_ack", {31'd0, ack_out}, 32'd1);
    chk("pre_rst_len", {28'd0, len_out}, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ack",   {31'd0, ack_out},   32'd0);
    chk("async_rst_len",   {28'd0, len_out},   32'd0);
    chk("async_rst_empty", {31'd0, empty_out}, 32'd1);
    chk("async_rst_data",  {24'd0, data_out},  32'd0);
`ifdef BYTE_QUEUE_ERR_EN
    chk("async_rst_err",   {31'd0, err_out},   32'd0);
`endif
    enqueue_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    enq(8'hA5, "post_rst");
    chk("post_rst_len", {28'd0, len_out}, 32'd1);
    pop_one(8'hA5);
`ifdef BYTE_QUEUE_ERR_EN
    chk("err_clear_traffic", {31'd0, err_out}, 32'd0);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("err_set_again", {31'd0, err_out}, 32'd1);
    enq(8'hB6, "err_traffic");
    pop_one(8'hB6);
    tick();
    chk("err_sticky", {31'd0, err_out}, 32'd1);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
